// File: rtl/serial_right_shifter_pkg.sv
// Shared constants and state encoding for the multi-cycle right shifter.
package serial_right_shifter_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Bit shifted into the vacated MSB: a copy of the sign for SRA, zero for SRL.
  function automatic logic fill_bit(input logic mode, input logic msb);
    return mode & msb;
  endfunction

endpackage

// File: rtl/serial_right_shifter_right_shift_1.sv
// Combinational single-bit right shift with an explicit fill bit for the MSB.
module right_shift_1 #(
  parameter int WIDTH = serial_right_shifter_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic             fill,
  output logic [WIDTH-1:0] out
);

  assign out = {fill, x[WIDTH-1:1]};

endmodule

// File: rtl/serial_right_shifter.sv
// Multi-cycle SRL/SRA: one bit position per clock, start/busy/done handshake.
// data_out holds the last completed result and changes only when done rises.
module serial_right_shifter #(
  parameter int WIDTH   = serial_right_shifter_pkg::WIDTH,
  parameter int SHAMT_W = serial_right_shifter_pkg::SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               done
);

  import serial_right_shifter_pkg::*;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   data_out_q;
  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] count_q;
  logic               mode_q;
  logic               accept;
  logic               zero_shift;
  logic               last_step;

  // A new request is taken whenever nothing is in flight (IDLE or DONE).
  assign accept     = start && (state_q != SHIFT);
  assign zero_shift = (shamt == '0);
  assign last_step  = (state_q == SHIFT) && (count_q == SHAMT_W'(1));

  right_shift_1 #(
    .WIDTH (WIDTH)
  ) u_shift (
    .x    (work_q),
    .fill (fill_bit(mode_q, work_q[WIDTH-1])),
    .out  (shifted)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; DONE behaves like IDLE so back-to-back issue works.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = zero_shift ? DONE : SHIFT;
        else        state_d = IDLE;
      end
      SHIFT: begin
        if (last_step) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on acceptance, one shift step per cycle while SHIFT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work_q  <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
    end else if (accept) begin
      work_q  <= data_in;
      count_q <= shamt;
      mode_q  <= arith;
    end else if (state_q == SHIFT) begin
      work_q  <= shifted;
      count_q <= count_q - SHAMT_W'(1);
    end
  end

  // Result register: loaded only on the cycle the machine enters DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_out_q <= '0;
    end else if (accept && zero_shift) begin
      data_out_q <= data_in;
    end else if (last_step) begin
      data_out_q <= shifted;
    end
  end

  assign data_out = data_out_q;
  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_serial_right_shifter.sv
// Scoreboard bench for serial_right_shifter: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_serial_right_shifter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        arith;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  serial_right_shifter dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .shamt    (shamt),
    .arith    (arith),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_out  = '0;
  int          next_free = 0;
  int          busy_lo   = 1;
  int          busy_hi   = 0;
  int          n_checks  = 0;
  int          n_fail    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain shift operators on the whole word.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                            input logic ar);
    logic signed [31:0] s;
    s = d;
    if (ar) return s >>> sh;
    return d >> sh;
  endfunction

  function automatic void model_reset();
    sb_q.delete();
    last_out  = '0;
    next_free = 0;
    busy_lo   = 1;
    busy_hi   = 0;
  endfunction

  // Drive one start cycle; the model decides whether the DUT is free to take it.
  task automatic issue(input logic [31:0] d, input logic [4:0] sh, input logic ar);
    exp_t e;
    start   = 1'b1;
    data_in = d;
    shamt   = sh;
    arith   = ar;
    if (cyc >= next_free) begin
      e.data = ref_shift(d, sh, ar);
      e.cyc  = cyc + int'(sh) + 1;
      sb_q.push_back(e);
      busy_lo   = cyc + 1;
      busy_hi   = cyc + int'(sh);
      next_free = cyc + int'(sh) + 1;
    end
    @(posedge clock);
    #1;
    start   = 1'b0;
    data_in = $urandom;
    shamt   = 5'($urandom);
    arith   = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() > 0 && guard < 60) begin
      idle(1);
      guard++;
    end
    idle(1);
    check("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: busy window, done timing, result value, and data_out hold.
  always @(negedge clock) begin
    if (!reset) begin
      check("busy", {31'd0, busy}, {31'd0, (cyc >= busy_lo) && (cyc <= busy_hi)});
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          check("done_cycle", 32'(cyc), 32'(sb_q[0].cyc));
          check("result", data_out, sb_q[0].data);
          last_out = sb_q[0].data;
          void'(sb_q.pop_front());
        end
      end else begin
        check("hold", data_out, last_out);
        if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
          check("missing_done", {31'd0, done}, 32'd1);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    shamt   = '0;
    arith   = 1'b0;

    // Asynchronous reset mid-cycle: outputs clear without a clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_data_out", data_out, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    check("post_rst_data_out", data_out, 32'h0);
    idle(2);

    // SRL by 4, SRA/SRL by 31 of the most negative value.
    issue(32'h8000_0000, 5'd4, 1'b0);
    drain();
    issue(32'h8000_0000, 5'd31, 1'b1);
    drain();
    issue(32'h8000_0000, 5'd31, 1'b0);
    drain();

    // Zero shift followed by back-to-back issue in the DONE cycle.
    issue(32'h1234_5678, 5'd0, 1'b0);
    issue(32'hF000_0000, 5'd2, 1'b1);
    drain();

    // Start while busy is ignored.
    issue(32'h0000_FF00, 5'd8, 1'b0);
    idle(2);
    issue(32'hFFFF_FFFF, 5'd1, 1'b1);
    drain();

    // Reset mid-operation aborts without a done pulse.
    issue(32'hDEAD_BEEF, 5'd20, 1'b1);
    repeat (9) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("abort_data_out", data_out, 32'h0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    idle(1);
    issue(32'h8765_4321, 5'd3, 1'b1);
    drain();

    // Randomized traffic; gaps let some starts land while busy.
    for (int i = 0; i < 60; i++) begin
      logic [4:0] sh;
      case ($urandom_range(0, 3))
        0:       sh = 5'd0;
        1:       sh = 5'd31;
        default: sh = 5'($urandom);
      endcase
      issue($urandom, sh, 1'($urandom));
      idle($urandom_range(0, 3));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_right_shifter.md
Name: serial_right_shifter

Overview:
Multi-cycle 32-bit right shifter covering SRL and SRA for the pipeline's multicycle execute path. It is the reverse-direction counterpart of the existing single-bit left-shift primitive. The block shifts one bit position per clock through a single-bit right-shift stage. It uses a start/busy/done handshake so the execute stage can stall on busy and capture the result on done.

Parameters:
WIDTH, 32, datapath width in bits.
SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
clock  input  1  single system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a new shift; sampled on the rising clock edge.
data_in  input  WIDTH  operand to shift; sampled with start.
shamt  input  SHAMT_W  shift amount, 0..31; sampled with start.
arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); sampled with start.
data_out  output  WIDTH  last completed result; held stable between completions.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when data_out is updated with a new result.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, data_out=0, busy=0, done=0, working register=0, count=0.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1, done=0.
  - DONE: busy=0, done=1.
- Acceptance: start is accepted at a rising edge only when state is IDLE or DONE, i.e. when busy=0.
  - On acceptance, latch data_in into the working register, shamt into the count, and arith into the mode flag.
  - If shamt=0, go to DONE and load data_out<=data_in.
  - Otherwise go to SHIFT.
- SHIFT, each cycle:
  - working register <= right shift by 1, with the vacated MSB = (mode ? reg[WIDTH-1] : 0).
  - count <= count-1.
  - When count==1: load data_out with the shifted value and go to DONE.
- DONE lasts exactly one cycle.
  - Next state is IDLE, or SHIFT/DONE if start is accepted in that same cycle (back-to-back issue allowed).
- Latency: done is high in cycle T+shamt+1, where T is the cycle in which start was sampled high. shamt=0 gives 1 cycle; shamt=31 gives 32 cycles.
- start while busy=1 is ignored: no queuing, and the in-flight operands are unchanged.
- data_out changes only in the cycle done rises. It is otherwise held, including during SHIFT of a later operation.
- Arithmetic fill uses the original sign bit, which propagates because the working MSB is refilled each step. SRA of a negative value by 31 yields 0xFFFFFFFF.
- Reset asserted mid-operation aborts immediately (asynchronously) to reset values. No done pulse is generated for the aborted operation.
- shamt is always in range (5 bits); no saturation logic is needed.

Decomposition:
- Shared package:
  - WIDTH and SHAMT_W constants.
  - State encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
- Sub-module right_shift_1: combinational single-bit right shift.
  - Ports x[WIDTH-1:0], fill, out[WIDTH-1:0].
  - out[WIDTH-1]=fill; out[i]=x[i+1].
  - Instantiated once in the SHIFT datapath.
- FSM, count, and registers live in the top module.

Test Plan:
- Reset then idle: assert reset mid-cycle, release -> data_out=0x00000000, busy=0, done=0 immediately and stably.
- SRL: start, data_in=0x80000000, shamt=4, arith=0 -> busy high 4 cycles, done pulses 5 cycles after start, data_out=0x08000000.
- SRA, negative operand: data_in=0x80000000, shamt=31, arith=1 -> done after 32 cycles, data_out=0xFFFFFFFF.
  - Same operand with arith=0 -> data_out=0x00000001.
- Zero shift plus back-to-back issue:
  - data_in=0x12345678, shamt=0 -> done next cycle, data_out=0x12345678.
  - start held during DONE with data_in=0xF0000000, shamt=2, arith=1 -> second done 3 cycles later, data_out=0xFC000000.
- Start while busy: issue shamt=8 on 0x0000FF00, pulse start with 0xFFFFFFFF at cycle 3 -> ignored; data_out=0x000000FF, exactly one done pulse.
- Reset mid-operation: start shamt=20, assert reset at cycle 10 -> data_out=0, busy=0, no done; a new start after release completes normally.
